// File: rtl/scc_pkg.sv
// Shared definitions for the SCC pipeline: instruction field positions,
// default widths and the immediate sign-extension helper.
package scc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int IMM_W_DEF  = 15;
  localparam int OPC_W      = 6;
  localparam int INSTR_W    = 32;
  localparam int MAX_W      = 64;

  localparam int OPC_LSB    = 26;
  localparam int IR_OP_BIT  = 25;
  localparam int RD_LSB     = 20;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 10;
  localparam int IMM_LSB    = 0;

  // Sign-extends the low w bits of v to MAX_W; callers truncate to their width.
  function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v, input int w);
    logic signed [MAX_W-1:0] t;
    t = $signed(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback or release.
// Queries are combinational; a same-cycle writeback hides the bit, and set beats clear.
module id_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              rel_en,
  input  logic [ADDR_W-1:0] rel_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q1_busy,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q2_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (rel_en) busy_d[rel_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A writeback landing this cycle resolves the hazard through the bypass path.
  assign q1_busy = busy_q[q1_addr] && (q1_addr != '0) && !(clr_en && clr_addr == q1_addr);
  assign q2_busy = busy_q[q2_addr] && (q2_addr != '0) && !(clr_en && clr_addr == q2_addr);

endmodule

// File: rtl/id_stage.sv
// Instruction decode: register read with WB bypass, immediate extension, RAW scoreboard.
// One-cycle latency; holds the bundle while EXE stalls and blocks fetch on hazards or flush.
module id_stage
  import scc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rs1_addr,
  output logic [ADDR_W-1:0]  rs2_addr,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  value1,
  output logic [DATA_W-1:0]  value2,
  output logic [DATA_W-1:0]  immediate,
  output logic               ir_op,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  rd
);

  logic [OPC_W-1:0]  in_opcode;
  logic              in_ir_op;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] op1_d;
  logic [DATA_W-1:0] op2_d;
  logic [DATA_W-1:0] imm_d;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              hazard;
  logic              can_load;
  logic              accept;
  logic              release_rd;

  assign in_opcode = instr[OPC_LSB +: OPC_W];
  assign in_ir_op  = instr[IR_OP_BIT];
  assign in_rd     = instr[RD_LSB +: ADDR_W];
  assign rs1_addr  = instr[RS1_LSB +: ADDR_W];
  assign rs2_addr  = instr[RS2_LSB +: ADDR_W];

  assign imm_d = DATA_W'(sign_extend(MAX_W'(instr[IMM_LSB +: IMM_W]), IMM_W));

  always_comb begin
    op1_d = rs1_data;
    op2_d = rs2_data;
    if (wb_en && wb_addr == rs1_addr) op1_d = wb_data;
    if (wb_en && wb_addr == rs2_addr) op2_d = wb_data;
    if (rs1_addr == '0) op1_d = '0;
    if (rs2_addr == '0) op2_d = '0;
  end

  assign hazard   = rs1_busy || (in_ir_op && rs2_busy);
  assign can_load = !out_valid || out_ready;
  assign in_ready = can_load && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Only a bundle that EXE did not take is killed; a consumed one stays issued.
  assign release_rd = flush && out_valid && !out_ready && (rd != '0);

  id_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept && (in_rd != '0)),
    .set_addr (in_rd),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rel_en   (release_rd),
    .rel_addr (rd),
    .q1_addr  (rs1_addr),
    .q1_busy  (rs1_busy),
    .q2_addr  (rs2_addr),
    .q2_busy  (rs2_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      value1    <= '0;
      value2    <= '0;
      immediate <= '0;
      ir_op     <= 1'b0;
      opcode    <= '0;
      rd        <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        value1    <= op1_d;
        value2    <= op2_d;
        immediate <= imm_d;
        ir_op     <= in_ir_op;
        opcode    <= in_opcode;
        rd        <= in_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, ALU-imm decode, RAW stall with bypass,
// backpressure, same-cycle set/clear, r0 handling, flush and mid-stream reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [31:0] immediate;
  logic        ir_op;
  logic [5:0]  opcode;
  logic [4:0]  rd;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  id_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value1    (value1),
    .value2    (value2),
    .immediate (immediate),
    .ir_op     (ir_op),
    .opcode    (opcode),
    .rd        (rd)
  );

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic irop,
                                     input logic [4:0] rd_f, input logic [4:0] rs1_f,
                                     input logic [14:0] low);
    return {opc, irop, rd_f, rs1_f, low};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD;
    rf[2] = 32'd5;

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_value1", value1, 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // ALU-imm: opcode 3, rd 4, rs1 2, imm 0x7FFF (rs2 field reads r31)
    in_valid = 1'b1;
    instr = mk(6'd3, 1'b0, 5'd4, 5'd2, 15'h7FFF);
    #1 chk("aluimm_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("aluimm_out_valid", 32'(out_valid), 32'd1);
    chk("aluimm_value1", value1, 32'd5);
    chk("aluimm_value2", value2, 32'h101F);
    chk("aluimm_imm", immediate, 32'hFFFFFFFF);
    chk("aluimm_rd", 32'(rd), 32'd4);
    chk("aluimm_opcode", 32'(opcode), 32'd3);
    chk("aluimm_ir_op", 32'(ir_op), 32'd0);

    // RAW stall on r4 until writeback, then bypass
    instr = mk(6'd5, 1'b0, 5'd1, 5'd4, 15'h0010);
    #1 chk("raw_stall0", 32'(in_ready), 32'd0);
    step();
    chk("raw_drained", 32'(out_valid), 32'd0);
    chk("raw_stall1", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
    #1 chk("raw_wb_ready", 32'(in_ready), 32'd1);
    step();
    wb_en = 1'b0;
    chk("raw_out_valid", 32'(out_valid), 32'd1);
    chk("raw_bypass_value1", value1, 32'd9);
    chk("raw_rd", 32'(rd), 32'd1);
    chk("raw_imm", immediate, 32'h10);
    chk("raw_value2_r0", value2, 32'd0);

    // Backpressure: held bundle (rd 1) stays put for 3 cycles
    out_ready = 1'b0;
    instr = mk(6'd8, 1'b1, 5'd0, 5'd3, {5'd5, 10'd0});
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_value1", value1, 32'd9);
      chk("bp_rd", 32'(rd), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_value1", value1, 32'h1003);
    chk("bp_next_value2", value2, 32'h1005);
    chk("bp_next_opcode", 32'(opcode), 32'd8);
    chk("bp_next_ir_op", 32'(ir_op), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Same-cycle set/clear of r7: set wins
    in_valid = 1'b1;
    instr = mk(6'd9, 1'b0, 5'd7, 5'd0, 15'h4000);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1 chk("sc_in_ready", 32'(in_ready), 32'd1);
    step();
    wb_en = 1'b0;
    chk("sc_value1_r0", value1, 32'd0);
    chk("sc_imm_neg", immediate, 32'hFFFFC000);
    chk("sc_rd", 32'(rd), 32'd7);
    instr = mk(6'd10, 1'b0, 5'd2, 5'd7, 15'd0);
    #1 chk("sc_r7_busy", 32'(in_ready), 32'd0);
    step();
    chk("sc_r7_still_busy", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    step();
    wb_en = 1'b0;
    chk("sc_r7_bypass", value1, 32'h55);
    instr = mk(6'd11, 1'b1, 5'd3, 5'd0, 15'd0);
    #1 chk("r0_no_stall", 32'(in_ready), 32'd1);
    step();
    chk("r0_value1", value1, 32'd0);
    chk("r0_value2", value2, 32'd0);

    // Flush of a held bundle rd 6 releases r6
    instr = mk(6'd12, 1'b0, 5'd6, 5'd0, 15'd5);
    step();
    chk("fl_rd6_loaded", 32'(rd), 32'd6);
    out_ready = 1'b0;
    instr = mk(6'd13, 1'b0, 5'd8, 5'd6, 15'd0);
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    #1 chk("fl_r6_released", 32'(in_ready), 32'd1);
    step();
    chk("fl_next_valid", 32'(out_valid), 32'd1);
    chk("fl_next_value1", value1, 32'h1006);
    chk("fl_next_rd", 32'(rd), 32'd8);

    // Flush while EXE consumes: r8 stays busy
    out_ready = 1'b1;
    flush = 1'b1;
    instr = mk(6'd14, 1'b0, 5'd9, 5'd8, 15'd0);
    #1 chk("flc_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("flc_out_valid", 32'(out_valid), 32'd0);
    #1 chk("flc_r8_busy", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
    step();
    wb_en = 1'b0;
    chk("flc_value1", value1, 32'h88);
    chk("flc_valid", 32'(out_valid), 32'd1);

    // Mid-stream reset clears bundle and busy bits (r9, r1 were busy)
    instr = mk(6'd15, 1'b1, 5'd10, 5'd9, {5'd1, 10'd0});
    #1 chk("pre_reset_stall", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1 chk("rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    #1 chk("rst_busy_cleared", 32'(in_ready), 32'd1);
    step();
    chk("rst_first_valid", 32'(out_valid), 32'd1);
    chk("rst_first_value1", value1, 32'h1009);
    chk("rst_first_value2", value2, 32'h1001);
    chk("rst_first_opcode", 32'(opcode), 32'd15);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
